lpif_state_sequencer: RTL and testbench
=======================================

// Module: lpif_state_sequencer
// PURPOSE
//  Sequences LPIF state requests into the main LTSSM on behalf of the adapter/link layer.
//  Accepts one request at a time and drives lpifStateRequest, then waits for matching lpifStateStatus.
//  Supervises each step with a timeout and recovers a hung link by pulsing forceDetect and retrying.
//  Sits between the adapter request interface and the main LTSSM control inputs.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles allowed in WAIT_LINKUP / WAIT_STATUS before timeout (>=2)
//  MAX_RETRIES     3     forceDetect recoveries per request before error (1..3)
//  FORCE_CYCLES    4     width of forceDetect pulse in cycles (>=1)
// PORTS
//  clk               in   1  clock
//  reset             in   1  async reset, active-high
//  req_valid         in   1  adapter request valid
//  req_state         in   4  requested LPIF state: 4'd0 reset, 4'd1 active, 4'd11 retrain
//  req_ready         out  1  high only in IDLE; handshake = req_valid & req_ready
//  linkUp            in   1  from LTSSM: training reached Configuration.Idle->L0
//  lpifStateStatus   in   4  from LTSSM: current LPIF state
//  lpifStateRequest  out  4  to LTSSM
//  forceDetect       out  1  to LTSSM: restart at Detect.Quiet
//  busy              out  1  ~IDLE
//  done              out  1  1-cycle pulse: status matched target
//  error             out  1  1-cycle pulse: illegal request or retries exhausted
//  retry_cnt         out  2  recoveries used for current request; cleared on accept
// BEHAVIOUR
//  Reset values: lpifStateRequest=4'd0, forceDetect=0, req_ready=1, busy/done/error=0, retry_cnt=0; FSM=IDLE.
//  Reset asserted mid-operation aborts immediately; no done/error emitted.
//  FSM (registered outputs, 1-cycle latency from state entry):
//   IDLE: req_ready=1; lpifStateRequest holds last value. On handshake latch target=req_state, clear retry_cnt.
//     target not in {0,1,11} -> error pulse, stay IDLE, lpifStateRequest unchanged.
//     target==1 and !linkUp -> WAIT_LINKUP; else -> ISSUE.
//   WAIT_LINKUP: lpifStateRequest=4'd0; timer runs. linkUp -> ISSUE. Timeout -> RECOVER.
//   ISSUE: lpifStateRequest=target; clear timer; -> WAIT_STATUS next cycle.
//   WAIT_STATUS: hold target. lpifStateStatus==target -> done pulse, IDLE. Timeout -> RECOVER.
//   RECOVER: if retry_cnt==MAX_RETRIES -> error pulse, lpifStateRequest=4'd0, IDLE.
//     else retry_cnt++, forceDetect=1 for FORCE_CYCLES, lpifStateRequest=4'd0, then WAIT_LINKUP (target 1) or ISSUE.
//  Timer: width $clog2(TIMEOUT_CYCLES+1), cleared on every state entry; timeout when count==TIMEOUT_CYCLES-1,
//   i.e. after exactly TIMEOUT_CYCLES cycles in the state.
//  Simultaneous events: status match (or linkUp) and timeout in the same cycle -> match wins.
//  req_valid while busy: ignored, not queued. A request equal to current status completes: ISSUE, WAIT_STATUS, done.
//  linkUp dropping during WAIT_STATUS for target 1: no action; the timeout governs.
// CONFIGURATION
//  LPIF_SEQ_RETRY_EN defined: RECOVER behaves as above.
//  Not defined: any timeout -> error pulse, lpifStateRequest=4'd0, IDLE; forceDetect tied 0; retry_cnt tied 0.
//   MAX_RETRIES and FORCE_CYCLES are unused.
// STRUCTURE
//  Package lpif_seq_pkg: LPIF encodings LPIF_RESET=4'd0, LPIF_ACTIVE=4'd1, LPIF_RETRAIN=4'd11;
//   FSM encodings IDLE, WAIT_LINKUP, ISSUE, WAIT_STATUS, RECOVER; legal-state check function.
//  Sub-module lpif_seq_timer: clear/enable counter with expire output; instantiated twice,
//   once for timeouts and once for forceDetect pulse width.
// TESTING
//  1. linkUp=1, req 4'd1, status follows 2 cycles after request -> lpifStateRequest=1, done pulse, retry_cnt=0.
//  2. req 4'd5 -> error pulse next cycle, still IDLE, lpifStateRequest unchanged.
//  3. linkUp=0, TIMEOUT_CYCLES=16, req 4'd1, linkUp rises after 40 cycles
//     -> forceDetect 4-cycle pulses at ~16 and ~36, retry_cnt=2, then done.
//  4. Status never matches, MAX_RETRIES=3 -> three forceDetect pulses, error pulse, lpifStateRequest=0, req_ready=1.
//  5. Status match on the timeout cycle -> done, no forceDetect. Req during WAIT_STATUS -> req_ready=0, dropped.
//  6. reset mid-RECOVER -> forceDetect=0 immediately, all outputs at reset values.
//     Repeat test 4 without LPIF_SEQ_RETRY_EN -> error at first timeout.

Source files
------------

// File: rtl/lpif_seq_pkg.sv
// Shared LPIF encodings, sequencer state encoding and the legal-request check.
package lpif_seq_pkg;

  localparam logic [3:0] LPIF_RESET   = 4'd0;
  localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
  localparam logic [3:0] LPIF_RETRAIN = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LINKUP,
    ISSUE,
    WAIT_STATUS,
    RECOVER
  } seqState_t;

  function automatic logic isLegalState(input logic [3:0] lpifState);
    return (lpifState == LPIF_RESET) || (lpifState == LPIF_ACTIVE) ||
           (lpifState == LPIF_RETRAIN);
  endfunction

endpackage

// File: rtl/lpif_seq_timer.sv
// Clear/enable cycle counter. expire is high on the LIMIT-th enabled cycle
// after a clear; the count parks there until the next clear.
module lpif_seq_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count enabled cycles since the last clear, saturating at the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/lpif_state_sequencer.sv
// LPIF state request sequencer in front of the main LTSSM.
// Build option: LPIF_SEQ_RETRY_EN enables forceDetect recovery and retries;
// without it any timeout ends the request with an error pulse.
//
// state       | meaning
// ------------|--------------------------------------------------------------
// IDLE        | ready for a request; request output holds its last value
// WAIT_LINKUP | active requested while link down; drive reset, wait for linkUp
// ISSUE       | drive the latched target for one cycle
// WAIT_STATUS | hold target until lpifStateStatus matches or timeout
// RECOVER     | pulse forceDetect for FORCE_CYCLES, then re-attempt
module lpif_state_sequencer
  import lpif_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned FORCE_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_state,
  output logic       req_ready,
  input  logic       linkUp,
  input  logic [3:0] lpifStateStatus,
  output logic [3:0] lpifStateRequest,
  output logic       forceDetect,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] retry_cnt
);

`ifdef LPIF_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [1:0] MAX_RETRY = 2'(MAX_RETRIES);

  seqState_t  state, stateNext;
  logic [3:0] target, targetNext;
  logic [3:0] reqNext;
  logic [1:0] retryCnt, retryNext;
  logic       fdReg;
  logic       doneNext, errorNext, timedOut;
  logic       stateChange, toExpire, fcExpire;

  // Both timers restart whenever a new state is entered.
  assign stateChange = (stateNext != state);

  lpif_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (stateChange),
    .enable ((state == WAIT_LINKUP) || (state == WAIT_STATUS)),
    .expire (toExpire)
  );

  lpif_seq_timer #(.LIMIT(FORCE_CYCLES)) u_force (
    .clk    (clk),
    .reset  (reset),
    .clear  (stateChange),
    .enable (state == RECOVER),
    .expire (fcExpire)
  );

  // Next-state and next-output decode; a match or linkUp beats a same-cycle timeout.
  always_comb begin
    stateNext  = state;
    targetNext = target;
    reqNext    = lpifStateRequest;
    retryNext  = retryCnt;
    doneNext   = 1'b0;
    errorNext  = 1'b0;
    timedOut   = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          targetNext = req_state;
          retryNext  = 2'd0;
          if (!isLegalState(req_state)) begin
            errorNext = 1'b1;
          end else if ((req_state == LPIF_ACTIVE) && !linkUp) begin
            stateNext = WAIT_LINKUP;
          end else begin
            stateNext = ISSUE;
          end
        end
      end
      WAIT_LINKUP: begin
        if (linkUp)        stateNext = ISSUE;
        else if (toExpire) timedOut  = 1'b1;
      end
      ISSUE: stateNext = WAIT_STATUS;
      WAIT_STATUS: begin
        if (lpifStateStatus == target) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end else if (toExpire) begin
          timedOut = 1'b1;
        end
      end
      RECOVER: begin
        if (fcExpire) stateNext = (target == LPIF_ACTIVE) ? WAIT_LINKUP : ISSUE;
      end
      default: stateNext = IDLE;
    endcase

    // Retry budget is checked at the timeout itself, so an exhausted request
    // goes straight back to IDLE without another forceDetect pulse.
    if (timedOut) begin
      if (!RETRY_EN || (retryCnt == MAX_RETRY)) begin
        errorNext = 1'b1;
        reqNext   = LPIF_RESET;
        stateNext = IDLE;
      end else begin
        retryNext = retryCnt + 2'd1;
        stateNext = RECOVER;
      end
    end

    case (stateNext)
      WAIT_LINKUP, RECOVER: reqNext = LPIF_RESET;
      ISSUE, WAIT_STATUS:   reqNext = targetNext;
      default: ;
    endcase
  end

  // State and registered outputs; outputs track the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      target           <= LPIF_RESET;
      lpifStateRequest <= LPIF_RESET;
      retryCnt         <= 2'd0;
      fdReg            <= 1'b0;
      req_ready        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state            <= stateNext;
      target           <= targetNext;
      lpifStateRequest <= reqNext;
      retryCnt         <= retryNext;
      fdReg            <= (stateNext == RECOVER);
      req_ready        <= (stateNext == IDLE);
      busy             <= (stateNext != IDLE);
      done             <= doneNext;
      error            <= errorNext;
    end
  end

  assign forceDetect = RETRY_EN ? fdReg : 1'b0;
  assign retry_cnt   = RETRY_EN ? retryCnt : 2'd0;

endmodule

// File: tb/tb_lpif_state_sequencer.sv
// Testbench for lpif_state_sequencer: directed and random request scenarios
// checked against a phase-level timing model of the sequencing rules.
module tb_lpif_state_sequencer;

`ifdef LPIF_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam int T = 16;
  localparam int M = 3;
  localparam int F = 4;
  localparam int BUDGET = 400;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_state = 4'd0;
  logic       req_ready;
  logic       linkUp = 1'b0;
  logic [3:0] lpifStateStatus = 4'hF;
  logic [3:0] lpifStateRequest;
  logic       forceDetect;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] retry_cnt;

  int compared = 0;
  int mismatched = 0;

  // model outputs
  int expKind, expEnd, expFd, expFirst, expRetry, expReq;
  int prevReq = 0;

  lpif_state_sequencer #(
    .TIMEOUT_CYCLES(T), .MAX_RETRIES(M), .FORCE_CYCLES(F)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_state        (req_state),
    .req_ready        (req_ready),
    .linkUp           (linkUp),
    .lpifStateStatus  (lpifStateStatus),
    .lpifStateRequest (lpifStateRequest),
    .forceDetect      (forceDetect),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .retry_cnt        (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic bit legalReq(input int s);
    return (s == 0) || (s == 1) || (s == 11);
  endfunction

  // Cycle 0 is the first cycle after the accepting edge. linkUp is high from
  // cycle L on (L<0: already high at accept); status equals target from cycle S on.
  // Each attempt waits at most T cycles; a timed-out attempt costs F recovery cycles.
  task automatic predict(input int tgt, input int L, input int S);
    int t, c, tc, r;
    bit wl, fin;
    expFd = 0; expFirst = -1; expRetry = 0;
    if (!legalReq(tgt)) begin
      expKind = 2; expEnd = 0; expReq = prevReq;
      return;
    end
    t = 0; r = 0; fin = 0;
    wl = (tgt == 1) && (L >= 0);
    while (!fin) begin
      tc = -1;
      if (wl) begin
        c = (L > t) ? L : t;
        if (c <= t + T - 1) begin t = c + 1; wl = 0; end
        else tc = t + T - 1;
      end else begin
        c = (S > t + 1) ? S : t + 1;
        if (c <= t + T) begin expKind = 1; expEnd = c + 1; expReq = tgt; fin = 1; end
        else tc = t + T;
      end
      if (tc >= 0) begin
        if (!RETRY || r == M) begin
          expKind = 2; expEnd = tc + 1; expReq = 0; fin = 1;
        end else begin
          r++;
          expFd += F;
          if (expFirst < 0) expFirst = tc + 1;
          t = tc + F + 1;
          wl = (tgt == 1);
        end
      end
    end
    expRetry = r;
  endtask

  // Issue one request from IDLE and observe it to completion; called at edge+1.
  task automatic runScenario(input int tgt, input int L, input int S, input bit noise);
    int obsEnd, obsKind, fdCnt, firstFd;
    predict(tgt, L, S);
    req_valid = 1'b1;
    req_state = 4'(tgt);
    linkUp = (L < 0);
    lpifStateStatus = 4'hF;
    obsEnd = -1; obsKind = 0; fdCnt = 0; firstFd = -1;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      req_valid = noise && legalReq(tgt) && (c < 2);
      req_state = 4'($urandom_range(0, 15));
      linkUp = (c >= L);
      lpifStateStatus = (c >= S) ? 4'(tgt) : 4'hF;
      if (c == 0) check("ready_at_accept", req_ready, legalReq(tgt) ? 0 : 1);
      if (forceDetect) begin
        fdCnt++;
        if (firstFd < 0) firstFd = c;
      end
      if (done || error) begin
        obsEnd = c;
        obsKind = {30'd0, error, done};
        break;
      end
    end
    req_valid = 1'b0;
    check("end_cycle", obsEnd, expEnd);
    check("end_kind", obsKind, expKind);
    check("fd_cycles", fdCnt, expFd);
    check("fd_first", firstFd, expFirst);
    check("retry_cnt", retry_cnt, expRetry);
    check("req_out", lpifStateRequest, expReq);
    check("busy_end", busy, 0);
    check("ready_end", req_ready, 1);
    prevReq = expReq;
    @(posedge clk); #1;
    check("pulse_width", {done, error}, 0);
  endtask

  initial begin
    int tgt, L, S, pick;
    bit hit;

    @(posedge clk); #1;
    check("rst_req", lpifStateRequest, 0);
    check("rst_fd", forceDetect, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_retry", retry_cnt, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    runScenario(1, -1, 2, 1'b0);      // link up, status follows quickly
    runScenario(5, -1, 0, 1'b0);      // illegal target
    runScenario(1, 40, 0, 1'b0);      // link comes up late
    runScenario(11, -1, NEVER, 1'b0); // status never matches
    runScenario(1, -1, 16, 1'b1);     // match on the timeout cycle, busy request dropped
    runScenario(0, -1, 0, 1'b1);      // already in requested state
    runScenario(14, -1, 0, 1'b0);     // illegal, request output must hold

    for (int n = 0; n < 25; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: tgt = 0;
        1, 2: tgt = 1;
        3: tgt = 11;
        default: tgt = $urandom_range(0, 15);
      endcase
      L = $urandom_range(0, 70) - 10;
      S = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 150);
      runScenario(tgt, L, S, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an operation (inside recovery when retries exist).
    req_valid = 1'b1; req_state = 4'd11; linkUp = 1'b1; lpifStateStatus = 4'hF;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (RETRY ? forceDetect : (c == 10)) begin hit = 1'b1; break; end
    end
    check("midop_reached", {busy, hit}, 2'b11);
    #3 reset = 1'b1;
    #1;
    check("midrst_fd", forceDetect, 0);
    check("midrst_req", lpifStateRequest, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_retry", retry_cnt, 0);
    check("midrst_pulses", {done, error}, 0);
    @(posedge clk); #1;
    check("midrst_hold", {busy, done, error, forceDetect}, 0);
    @(negedge clk) reset = 1'b0;
    prevReq = 0;
    @(posedge clk); #1;
    runScenario(11, -1, NEVER, 1'b0);
    runScenario(1, 5, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
